// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus arbiter: grants up to NUM_PORTS result requests per
// cycle and drives the winners onto registered broadcast ports one cycle later.
module cdb_arbiter #(
   parameter int NUM_REQ   = 8,
   parameter int NUM_PORTS = 2,
   parameter int DATA_W    = 32,
   parameter int TAG_W     = 5,
   parameter int SRC_W     = $clog2(NUM_REQ)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flush,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic [NUM_PORTS-1:0]        cdb_valid,
   output logic [NUM_PORTS*TAG_W-1:0]  cdb_tag,
   output logic [NUM_PORTS*DATA_W-1:0] cdb_data,
   output logic [NUM_PORTS*SRC_W-1:0]  cdb_src
);

   logic [SRC_W-1:0]     rr_ptr_reg;
   logic [SRC_W-1:0]     rr_ptr_next;
   logic [TAG_W-1:0]     tag_arr [NUM_REQ];
   logic [DATA_W-1:0]    data_arr [NUM_REQ];
   logic [SRC_W-1:0]     scan_src [NUM_REQ];
   logic [2*NUM_REQ-1:0] rot_wide;
   logic [2*NUM_REQ-1:0] unrot_wide;
   logic [NUM_REQ-1:0]   rot_valid;
   logic [NUM_REQ-1:0]   rot_grant;
   logic [NUM_PORTS-1:0] sel_valid;
   logic [SRC_W-1:0]     sel_src [NUM_PORTS];
   logic [SRC_W-1:0]     last_src;
   logic                 any_grant;

   logic                 cdb_valid_reg [NUM_PORTS];
   logic [TAG_W-1:0]     cdb_tag_reg [NUM_PORTS];
   logic [DATA_W-1:0]    cdb_data_reg [NUM_PORTS];
   logic [SRC_W-1:0]     cdb_src_reg [NUM_PORTS];

   // scan_src[j] is the requester index visited j steps after rr_ptr
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
         logic [SRC_W:0] scan_sum;
         assign tag_arr[gi]  = req_tag[gi*TAG_W +: TAG_W];
         assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
         assign scan_sum     = {1'b0, rr_ptr_reg} + (SRC_W+1)'(gi);
         assign scan_src[gi] = (scan_sum >= (SRC_W+1)'(NUM_REQ)) ?
                               SRC_W'(scan_sum - (SRC_W+1)'(NUM_REQ)) : SRC_W'(scan_sum);
      end
   endgenerate

   // Rotate so bit 0 is the highest-priority requester, scan, then rotate back
   assign rot_wide   = {req_valid, req_valid} >> rr_ptr_reg;
   assign rot_valid  = rot_wide[NUM_REQ-1:0];
   assign unrot_wide = {rot_grant, rot_grant} << rr_ptr_reg;
   assign req_ready  = unrot_wide[2*NUM_REQ-1:NUM_REQ];

   always_comb begin
      int cnt;
      cnt       = 0;
      rot_grant = '0;
      sel_valid = '0;
      last_src  = rr_ptr_reg;
      any_grant = 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         sel_src[p] = '0;
      end
      if (rst && !flush) begin
         for (int j = 0; j < NUM_REQ; j++) begin
            if (rot_valid[j] && cnt < NUM_PORTS) begin
               rot_grant[j] = 1'b1;
               for (int p = 0; p < NUM_PORTS; p++) begin
                  if (cnt == p) begin
                     sel_valid[p] = 1'b1;
                     sel_src[p]   = scan_src[j];
                  end
               end
               last_src  = scan_src[j];
               any_grant = 1'b1;
               cnt       = cnt + 1;
            end
         end
      end
   end

   always_comb begin
      rr_ptr_next = rr_ptr_reg;
      if (any_grant) begin
         rr_ptr_next = (last_src == SRC_W'(NUM_REQ-1)) ? '0 : last_src + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rr_ptr_reg <= '0;
      end else begin
         rr_ptr_reg <= rr_ptr_next;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
         always_ff @(posedge clk) begin
            if (!rst || !sel_valid[gi]) begin
               cdb_valid_reg[gi] <= 1'b0;
               cdb_tag_reg[gi]   <= '0;
               cdb_data_reg[gi]  <= '0;
               cdb_src_reg[gi]   <= '0;
            end else begin
               cdb_valid_reg[gi] <= 1'b1;
               cdb_tag_reg[gi]   <= tag_arr[sel_src[gi]];
               cdb_data_reg[gi]  <= data_arr[sel_src[gi]];
               cdb_src_reg[gi]   <= sel_src[gi];
            end
         end
         assign cdb_valid[gi]                  = cdb_valid_reg[gi];
         assign cdb_tag[gi*TAG_W +: TAG_W]     = cdb_tag_reg[gi];
         assign cdb_data[gi*DATA_W +: DATA_W]  = cdb_data_reg[gi];
         assign cdb_src[gi*SRC_W +: SRC_W]     = cdb_src_reg[gi];
      end
   endgenerate

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios then random traffic, all checked against
// a queue-based round-robin reference model.
module tb_cdb_arbiter;
   localparam int NR = 8;
   localparam int NP = 2;
   localparam int DW = 32;
   localparam int TW = 5;
   localparam int SW = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   logic [NR-1:0]     req_valid;
   logic [NR*TW-1:0]  req_tag;
   logic [NR*DW-1:0]  req_data;
   logic [NR-1:0]     req_ready;
   logic [NP-1:0]     cdb_valid;
   logic [NP*TW-1:0]  cdb_tag;
   logic [NP*DW-1:0]  cdb_data;
   logic [NP*SW-1:0]  cdb_src;

   cdb_arbiter #(.NUM_REQ(NR), .NUM_PORTS(NP), .DATA_W(DW), .TAG_W(TW)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data),
      .req_ready(req_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
      .cdb_data(cdb_data), .cdb_src(cdb_src)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Requester-side state and reference model state
   logic          u_valid [NR];
   logic [TW-1:0] u_tag [NR];
   logic [DW-1:0] u_data [NR];
   int            ptr = 0;
   logic [NR-1:0]    last_grant;
   logic [NP-1:0]    exp_v = '0;
   logic [NP*TW-1:0] exp_t = '0;
   logic [NP*DW-1:0] exp_d = '0;
   logic [NP*SW-1:0] exp_s = '0;
   int            wait_cnt [NR];
   int            bcast5 = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic apply();
      for (int i = 0; i < NR; i++) begin
         req_valid[i]          = u_valid[i];
         req_tag[i*TW +: TW]   = u_tag[i];
         req_data[i*DW +: DW]  = u_data[i];
      end
   endtask

   task automatic set_all(input logic v);
      for (int i = 0; i < NR; i++) u_valid[i] = v;
   endtask

   // One clock: check grants and the broadcast from the previous cycle, advance the model
   task automatic cycle();
      int wins[$];
      logic [NR-1:0] exp_ready;
      apply();
      @(negedge clk);
      exp_ready = '0;
      wins = {};
      if (rst && !flush) begin
         for (int k = 0; k < NR; k++) begin
            int i;
            i = (ptr + k) % NR;
            if (u_valid[i] && wins.size() < NP) begin
               wins.push_back(i);
               exp_ready[i] = 1'b1;
            end
         end
      end
      check("req_ready", 64'(req_ready), 64'(exp_ready));
      check("cdb_valid", 64'(cdb_valid), 64'(exp_v));
      check("cdb_tag", 64'(cdb_tag), 64'(exp_t));
      check("cdb_data", 64'(cdb_data), 64'(exp_d));
      check("cdb_src", 64'(cdb_src), 64'(exp_s));
      for (int p = 0; p < NP; p++) begin
         if (cdb_valid[p] && cdb_src[p*SW +: SW] == 3'd5 && cdb_data[p*DW +: DW] == 32'hA5) bcast5++;
      end
      for (int i = 0; i < NR; i++) begin
         if (!rst || flush || !u_valid[i]) wait_cnt[i] = 0;
         else if (req_ready[i]) begin
            check("fairness", 64'(wait_cnt[i] < 4), 64'd1);
            wait_cnt[i] = 0;
         end else wait_cnt[i]++;
      end
      exp_v = '0; exp_t = '0; exp_d = '0; exp_s = '0;
      for (int p = 0; p < wins.size(); p++) begin
         exp_v[p]            = 1'b1;
         exp_t[p*TW +: TW]   = u_tag[wins[p]];
         exp_d[p*DW +: DW]   = u_data[wins[p]];
         exp_s[p*SW +: SW]   = SW'(wins[p]);
      end
      if (!rst) ptr = 0;
      else if (wins.size() > 0) ptr = (wins[wins.size()-1] + 1) % NR;
      last_grant = exp_ready;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      flush = 1'b0;
      for (int i = 0; i < NR; i++) begin
         u_valid[i] = 1'b1;
         u_tag[i]   = TW'(i);
         u_data[i]  = 32'h100 + i;
         wait_cnt[i] = 0;
      end
      apply();
      @(posedge clk);
      #1;

      // Reset held with everything valid
      cycle();
      cycle();
      rst = 1'b1;

      // Saturation: (0,1),(2,3),(4,5),(6,7),(0,1)
      for (int c = 0; c < 5; c++) cycle();

      // Move pointer to 6, then wrap-around with units 7 and 1
      set_all(1'b0);
      u_valid[5] = 1'b1;
      cycle();
      set_all(1'b0);
      u_valid[7] = 1'b1;
      u_valid[1] = 1'b1;
      cycle();
      set_all(1'b0);
      cycle();

      // Single request from unit 3
      u_valid[3] = 1'b1;
      u_tag[3]   = 5'd5;
      u_data[3]  = 32'hDEADBEEF;
      cycle();
      set_all(1'b0);
      cycle();

      // Flush with all valid, then resume from the same pointer
      set_all(1'b1);
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      cycle();
      set_all(1'b0);

      // Unit 5 waits behind 6, 7, 0 and must be broadcast exactly once
      u_data[5] = 32'hA5;
      bcast5 = 0;
      u_valid[6] = 1'b1; u_valid[7] = 1'b1; u_valid[0] = 1'b1; u_valid[5] = 1'b1;
      cycle();
      for (int i = 0; i < NR; i++) if (last_grant[i]) u_valid[i] = 1'b0;
      cycle();
      for (int i = 0; i < NR; i++) if (last_grant[i]) u_valid[i] = 1'b0;
      cycle();
      cycle();
      check("unit5_once", 64'(bcast5), 64'd1);

      // Random traffic: ungranted requesters hold their payload
      for (int c = 0; c < 400; c++) begin
         rst   = (c == 200) ? 1'b0 : 1'b1;
         flush = ($urandom_range(0, 19) == 0);
         cycle();
         for (int i = 0; i < NR; i++) begin
            if (last_grant[i] || !u_valid[i]) begin
               u_valid[i] = ($urandom_range(0, 3) != 0);
               u_tag[i]   = TW'($urandom);
               u_data[i]  = $urandom;
            end
         end
      end
      rst = 1'b1;
      flush = 1'b0;
      set_all(1'b0);
      cycle();
      cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter that shares the common data bus (CDB) broadcast ports between the functional units behind the reservation stations: the ALUs, CMP, branch CMP and load/store address ALU. Each unit raises a result request with a ROB tag and data. Up to NUM_PORTS requests are granted per cycle and driven onto registered CDB ports one cycle later. The reservation stations, regfile and ROB snoop those ports. A flush input drops in-flight broadcasts on mispredict.

## Interface

Parameters:
- NUM_REQ, 8, number of requesting functional units (index 0..NUM_REQ-1)
- NUM_PORTS, 2, number of CDB broadcast ports; 1 ≤ NUM_PORTS ≤ NUM_REQ
- DATA_W, 32, result width
- TAG_W, 5, ROB tag width
- SRC_W, $clog2(NUM_REQ), requester index width

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- flush  in  1  ROB mispredict flush
- req_valid  in  NUM_REQ  per-unit result pending
- req_tag  in  NUM_REQ*TAG_W  per-unit ROB tag, unit i at [i*TAG_W +: TAG_W]
- req_data  in  NUM_REQ*DATA_W  per-unit result, unit i at [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  combinational grant; unit's request is consumed this cycle
- cdb_valid  out  NUM_PORTS  registered broadcast valid per port
- cdb_tag  out  NUM_PORTS*TAG_W  registered tag per port
- cdb_data  out  NUM_PORTS*DATA_W  registered data per port
- cdb_src  out  NUM_PORTS*SRC_W  registered index of the granted requester

## Operation

- State:
  - rr_ptr (SRC_W bits), the highest-priority requester.
  - Output registers for every cdb_* port.
- Selection:
  - Scan requesters in order rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - The first NUM_PORTS with req_valid=1 are granted.
  - The k-th winner in scan order goes to port k.
- req_ready[i]=1 iff requester i is granted this cycle. It is never 1 when req_valid[i]=0.
- Handshake: a transfer occurs when req_valid[i]&req_ready[i]. A requester not granted holds valid, tag and data stable; the arbiter never drops a presented request.
- Pointer update: if ≥1 grant, rr_ptr ← (index of last winner + 1) mod NUM_REQ. Otherwise rr_ptr is unchanged. Wrap-around uses modulo NUM_REQ; for non-power-of-2 NUM_REQ, index NUM_REQ-1 wraps to 0.
- Ports with no winner: cdb_valid=0, and cdb_tag, cdb_data and cdb_src are loaded with 0.
- Fairness: any continuously valid requester is granted within ceil(NUM_REQ/NUM_PORTS) cycles.
- Flush (flush=1):
  - All req_ready=0 that cycle.
  - Next-cycle cdb_valid=0 with payload zeroed.
  - rr_ptr unchanged.
  - Requesters are responsible for dropping their own flushed entries.
- Reset (rst=0 at an edge) takes precedence over flush and requests:
  - rr_ptr=0.
  - All cdb_* outputs 0.
  - req_ready forced 0 while rst=0.
  - A reset mid-burst discards all pending grants; nothing is broadcast for the reset cycle.

## Timing

- Grant latency: req_ready is combinational, asserted in the same cycle req_valid is seen.
- Broadcast latency: the granted payload appears on cdb_* at the next rising edge and is held exactly one cycle, unless re-granted.
- Throughput: up to NUM_PORTS results per cycle sustained; no bubbles between consecutive grants.
- Simultaneous events: the same requester may be granted on consecutive cycles if it presents a new result. Its old result is already consumed.
- Output reset values: cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, req_ready=0.
- Combinational path: req_valid→req_ready passes through a priority scan of depth NUM_REQ. It must not depend on cdb_* registers.

## Test plan

Defaults: NUM_REQ=8, NUM_PORTS=2.

1. Reset:
   - Stimulus: rst=0 for 2 cycles with all req_valid=1.
   - Response: req_ready=0 and cdb_valid=00 throughout. After release, the first grants are units 0 and 1.
2. Saturation:
   - Stimulus: all 8 valid every cycle, tag=i, data=0x100+i.
   - Response: grants (0,1),(2,3),(4,5),(6,7),(0,1). Each pair appears on ports 0/1 the following cycle with matching cdb_tag, cdb_data and cdb_src.
3. Wrap-around:
   - Stimulus: rr_ptr=6; only units 7 and 1 valid.
   - Response: port0 = unit 7 and port1 = unit 1 next cycle; rr_ptr becomes 2.
4. Single request:
   - Stimulus: only unit 3 valid, tag=5, data=0xDEADBEEF.
   - Response: req_ready[3]=1 the same cycle. Next cycle cdb_valid=01, port0 tag=5, data=0xDEADBEEF, src=3; port1 all zero. rr_ptr becomes 4.
5. Flush:
   - Stimulus: all valid, flush=1 for one cycle.
   - Response: req_ready=0 that cycle and cdb_valid=00 the next. rr_ptr unchanged, and the following cycle grants resume from the same pointer.
6. Hold under contention:
   - Stimulus: unit 5 valid with data 0xA5 while 3 higher-priority units are granted first.
   - Response: unit 5 is never granted with changed data, is granted within 4 cycles, and is broadcast exactly once.
